// File: rtl/wb_commit.sv
// Writeback commit stage: retires ALU results and loads into registered
// forwarding/regfile outputs, holding upstream while a load waits for data.
module wb_commit #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_wreg,
    input  logic [31:0] in_result,
    input  logic        in_is_load,
    input  logic [1:0]  in_ldsize,
    input  logic        in_ldsigned,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  wreg_b,
    output logic [31:0] w_data_b,
    output logic        we_b,
    output logic        stall,
    output logic        err
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    lwreg_q, lwreg_d;
    logic [1:0]    lsize_q, lsize_d;
    logic          lsigned_q, lsigned_d;
    logic [1:0]    laddr_q, laddr_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   data_q, data_d;
    logic          we_q, we_d;
    logic          err_q, err_d;

    logic          commit;
    logic [4:0]    c_wreg;
    logic [31:0]   c_data;

    // Lane select then extend; half loads only look at the upper address bit.
    function automatic logic [31:0] ext(input logic [31:0] rdata, input logic [1:0] size,
                                        input logic sgn, input logic [1:0] alo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (alo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = alo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    r = {{24{sgn & b[7]}}, b};
            2'd1:    r = {{16{sgn & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lwreg_d   = lwreg_q;
        lsize_d   = lsize_q;
        lsigned_d = lsigned_q;
        laddr_d   = laddr_q;
        err_d     = err_q;
        commit    = 1'b0;
        c_wreg    = 5'd0;
        c_data    = 32'd0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!in_is_load) begin
                        commit = 1'b1;
                        c_wreg = in_wreg;
                        c_data = in_result;
                    end else if (mem_rvalid) begin
                        commit = 1'b1;
                        c_wreg = in_wreg;
                        c_data = ext(mem_rdata, in_ldsize, in_ldsigned, in_addr_lo);
                    end else begin
                        lwreg_d   = in_wreg;
                        lsize_d   = in_ldsize;
                        lsigned_d = in_ldsigned;
                        laddr_d   = in_addr_lo;
                        cnt_d     = '0;
                        state_d   = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    commit  = 1'b1;
                    c_wreg  = lwreg_q;
                    c_data  = ext(mem_rdata, lsize_q, lsigned_q, laddr_q);
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Load is abandoned: flag it and reopen the stage.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wreg_d = commit ? c_wreg : 5'd0;
        we_d   = commit && (c_wreg != 5'd0);
        data_d = commit ? c_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lwreg_q   <= '0;
            lsize_q   <= '0;
            lsigned_q <= 1'b0;
            laddr_q   <= '0;
            wreg_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lwreg_q   <= lwreg_d;
            lsize_q   <= lsize_d;
            lsigned_q <= lsigned_d;
            laddr_q   <= laddr_d;
            wreg_q    <= wreg_d;
            data_q    <= data_d;
            we_q      <= we_d;
            err_q     <= err_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign stall    = (state_q == LOAD_WAIT);
    assign wreg_b   = wreg_q;
    assign w_data_b = data_q;
    assign we_b     = we_q;
    assign err      = err_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: vector table, hand-built multi-cycle sequences and
// random traffic checked against a cycle-level behavioural model.
module tb_wb_commit;

    localparam int TO = 4;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  wreg;
        logic [31:0] result;
        logic        is_load;
        logic [1:0]  ldsize;
        logic        ldsigned;
        logic [1:0]  addr_lo;
        logic        rvalid;
        logic [31:0] rdata;
    } in_t;

    typedef struct {
        in_t         in;
        logic [4:0]  e_wreg;
        logic [31:0] e_data;
        logic        e_we;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_is_load, in_ldsigned, mem_rvalid;
    logic [4:0]  in_wreg, wreg_b;
    logic [31:0] in_result, mem_rdata, w_data_b;
    logic [1:0]  in_ldsize, in_addr_lo;
    logic        we_b, stall, err;

    always #5 clk = ~clk;

    wb_commit #(.TIMEOUT(TO), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_wreg(in_wreg), .in_result(in_result), .in_is_load(in_is_load),
        .in_ldsize(in_ldsize), .in_ldsigned(in_ldsigned), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wreg_b(wreg_b),
        .w_data_b(w_data_b), .we_b(we_b), .stall(stall), .err(err)
    );

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];

    // Reference model state
    bit          m_busy;
    int          m_waited;
    in_t         m_pend;
    bit          m_err;
    logic [4:0]  e_wreg;
    logic        e_we;
    logic [31:0] e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [31:0] rdata, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] a);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rdata >> (8 * int'(a))) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = (rdata >> (16 * (int'(a) / 2))) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic model_step(input in_t v);
        bit          commit;
        logic [4:0]  cw;
        logic [31:0] cd;
        commit = 0;
        cw = 5'd0;
        cd = 32'd0;
        if (v.rst) begin
            m_busy = 0; m_waited = 0; m_err = 0;
            e_wreg = 5'd0; e_we = 1'b0; e_data = 32'd0;
            exp_q.delete();
            return;
        end
        if (!m_busy) begin
            if (v.valid) begin
                if (!v.is_load) begin
                    commit = 1; cw = v.wreg; cd = v.result;
                end else if (v.rvalid) begin
                    commit = 1; cw = v.wreg;
                    cd = ref_ext(v.rdata, v.ldsize, v.ldsigned, v.addr_lo);
                end else begin
                    m_busy = 1; m_waited = 0; m_pend = v;
                end
            end
        end else if (v.rvalid) begin
            commit = 1; cw = m_pend.wreg;
            cd = ref_ext(v.rdata, m_pend.ldsize, m_pend.ldsigned, m_pend.addr_lo);
            m_busy = 0;
        end else begin
            m_waited++;
            if (m_waited == TO) begin
                m_err = 1;
                m_busy = 0;
            end
        end
        if (commit) begin
            e_wreg = cw;
            e_we   = (cw != 5'd0);
            e_data = cd;
            if (e_we) exp_q.push_back({cw, cd});
        end else begin
            e_wreg = 5'd0;
            e_we   = 1'b0;
        end
    endtask

    task automatic drive(input in_t v);
        logic [36:0] got;
        rst = v.rst; in_valid = v.valid; in_wreg = v.wreg; in_result = v.result;
        in_is_load = v.is_load; in_ldsize = v.ldsize; in_ldsigned = v.ldsigned;
        in_addr_lo = v.addr_lo; mem_rvalid = v.rvalid; mem_rdata = v.rdata;
        model_step(v);
        @(posedge clk);
        #1;
        chk("wreg_b", 32'(wreg_b), 32'(e_wreg));
        chk("we_b", 32'(we_b), 32'(e_we));
        chk("w_data_b", w_data_b, e_data);
        chk("stall", 32'(stall), 32'(m_busy));
        chk("in_ready", 32'(in_ready), 32'(!m_busy));
        chk("err", 32'(err), 32'(m_err));
        if (we_b) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%h expected=none", {wreg_b, w_data_b});
            end else begin
                got = exp_q.pop_front();
                chk("sb_commit_wreg", 32'({wreg_b}), 32'(got[36:32]));
                chk("sb_commit_data", w_data_b, got[31:0]);
            end
        end
        chk("sb_missed", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    function automatic in_t mk(input logic valid, input logic [4:0] wreg, input logic [31:0] result,
                               input logic is_load, input logic [1:0] sz, input logic sg,
                               input logic [1:0] a, input logic rv, input logic [31:0] rd);
        in_t v;
        v.rst = 1'b0; v.valid = valid; v.wreg = wreg; v.result = result;
        v.is_load = is_load; v.ldsize = sz; v.ldsigned = sg; v.addr_lo = a;
        v.rvalid = rv; v.rdata = rd;
        return v;
    endfunction

    vec_t vecs[12];
    in_t  ld;
    in_t  rv;

    initial begin
        vecs[0]  = '{mk(1, 5,  32'h12345678, 0, 0, 0, 0, 0, 0),            5'd5,  32'h12345678, 1'b1};
        vecs[1]  = '{mk(1, 0,  32'hFFFFFFFF, 0, 0, 0, 0, 0, 0),            5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{mk(1, 9,  0, 1, 0, 1, 3, 1, 32'h80AABBCC),            5'd9,  32'hFFFFFF80, 1'b1};
        vecs[3]  = '{mk(1, 9,  0, 1, 0, 0, 3, 1, 32'h80AABBCC),            5'd9,  32'h00000080, 1'b1};
        vecs[4]  = '{mk(1, 1,  0, 1, 0, 1, 0, 1, 32'h80AABBCC),            5'd1,  32'hFFFFFFCC, 1'b1};
        vecs[5]  = '{mk(1, 2,  0, 1, 0, 0, 1, 1, 32'h80AABBCC),            5'd2,  32'h000000BB, 1'b1};
        vecs[6]  = '{mk(1, 3,  0, 1, 1, 1, 2, 1, 32'hBEEF1234),            5'd3,  32'hFFFFBEEF, 1'b1};
        vecs[7]  = '{mk(1, 4,  0, 1, 1, 0, 3, 1, 32'hBEEF1234),            5'd4,  32'h0000BEEF, 1'b1};
        vecs[8]  = '{mk(1, 6,  0, 1, 1, 1, 1, 1, 32'hBEEF1234),            5'd6,  32'h00001234, 1'b1};
        vecs[9]  = '{mk(1, 7,  0, 1, 2, 1, 3, 1, 32'hDEADBEEF),            5'd7,  32'hDEADBEEF, 1'b1};
        vecs[10] = '{mk(1, 31, 0, 1, 3, 1, 1, 1, 32'h80000001),            5'd31, 32'h80000001, 1'b1};
        vecs[11] = '{mk(0, 12, 32'h5555AAAA, 1, 0, 0, 0, 1, 32'h12345678), 5'd0,  32'h80000001, 1'b0};

        // Reset
        ld = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld.rst = 1'b1;
        drive(ld);
        drive(ld);
        chk("reset_wreg_b", 32'(wreg_b), 32'd0);
        chk("reset_w_data_b", w_data_b, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Vector table
        foreach (vecs[i]) begin
            drive(vecs[i].in);
            chk($sformatf("vec%0d_wreg", i), 32'(wreg_b), 32'(vecs[i].e_wreg));
            chk($sformatf("vec%0d_data", i), w_data_b, vecs[i].e_data);
            chk($sformatf("vec%0d_we", i), 32'(we_b), 32'(vecs[i].e_we));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
        end

        // Three-wait unsigned half load, upstream holds its inputs
        ld = mk(1, 12, 0, 1, 1, 0, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(ld);
            chk("hw_stall", 32'(stall), 32'd1);
            chk("hw_in_ready", 32'(in_ready), 32'd0);
            chk("hw_wreg_idle", 32'(wreg_b), 32'd0);
        end
        ld.rvalid = 1'b1;
        ld.rdata  = 32'hBEEF1234;
        drive(ld);
        chk("hw_commit_wreg", 32'(wreg_b), 32'd12);
        chk("hw_commit_data", w_data_b, 32'h0000BEEF);
        chk("hw_stall_done", 32'(stall), 32'd0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Back-to-back ALU then zero-wait load
        drive(mk(1, 8, 32'h00000011, 0, 0, 0, 0, 0, 0));
        chk("b2b_alu_wreg", 32'(wreg_b), 32'd8);
        drive(mk(1, 10, 0, 1, 2, 0, 0, 1, 32'h00000022));
        chk("b2b_ld_wreg", 32'(wreg_b), 32'd10);
        chk("b2b_ld_data", w_data_b, 32'h00000022);
        chk("b2b_no_stall", 32'(stall), 32'd0);

        // Timeout: load never answered
        drive(mk(1, 13, 0, 1, 2, 0, 0, 0, 0));
        for (int i = 0; i < TO; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
            chk("to_err", 32'(err), (i == TO - 1) ? 32'd1 : 32'd0);
            chk("to_stall", 32'(stall), (i == TO - 1) ? 32'd0 : 32'd1);
        end
        chk("to_no_commit", 32'(we_b), 32'd0);

        // Reset in the middle of a second load, then a late rvalid
        drive(mk(1, 14, 0, 1, 2, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ld = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld.rst = 1'b1;
        drive(ld);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_data", w_data_b, 32'd0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D));
        chk("late_rvalid_we", 32'(we_b), 32'd0);
        chk("late_rvalid_data", w_data_b, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            rv = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), $urandom);
            rv.rst = ($urandom_range(0, 63) == 0);
            drive(rv);
        end

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Writeback-stage producer for the operand-forwarding network and the register file write port.
- Accepts one retiring instruction per cycle from the MEM stage: ALU result, or load that completes on the data-memory read handshake.
- Drives registered wreg_b / w_data_b / we_b: the consumer-side forwarding units compare rs/rt against them and the regfile writes them.
- Stalls upstream while a load is outstanding.
- Performs load byte/half extraction and sign/zero extension.

Parameters:
- TIMEOUT, 64, max cycles in LOAD_WAIT before err is raised; 1..255.
- CW, 8, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  stage accepts; in_valid&&in_ready = transfer
- in_wreg  input  5  destination register; 0 = no write
- in_result  input  32  ALU result (non-load)
- in_is_load  input  1  instruction is a load
- in_ldsize  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- in_ldsigned  input  1  sign-extend byte/half
- in_addr_lo  input  2  load address bits [1:0]
- mem_rvalid  input  1  read data valid this cycle
- mem_rdata  input  32  read data, little-endian word
- wreg_b  output  5  committed destination; 0 when nothing commits
- w_data_b  output  32  committed data
- we_b  output  1  regfile write enable
- stall  output  1  upstream hold
- err  output  1  sticky load-timeout flag

Behaviour:
- Reset: state IDLE; wreg_b = 0, w_data_b = 0, we_b = 0, err = 0, counter = 0, latched load fields = 0.
- Outputs wreg_b, w_data_b and we_b are registered. Every commit is visible exactly one cycle after its trigger cycle.
- A cycle with no commit forces wreg_b = 0, we_b = 0 and holds w_data_b. Consumers then never match stale data (rt = 0 always reads zero).
- we_b = 1 iff a commit occurs and its wreg != 0. A commit to r0 drives wreg_b = 0, we_b = 0.
- in_ready = (state == IDLE). stall = (state == LOAD_WAIT), combinational from state.
- IDLE, transfer with !in_is_load: commit in_result to in_wreg.
- IDLE, transfer with in_is_load and mem_rvalid in the same cycle: commit ext(mem_rdata) with zero wait. State stays IDLE.
- IDLE, transfer with in_is_load and !mem_rvalid:
  - Latch wreg, ldsize, ldsigned, addr_lo.
  - Counter <= 0; go to LOAD_WAIT. No commit.
- LOAD_WAIT, mem_rvalid: commit ext(mem_rdata) using the latched fields; go to IDLE.
- LOAD_WAIT, !mem_rvalid:
  - Counter increments, saturating.
  - When counter reaches TIMEOUT-1 without rvalid: err <= 1, commit nothing, go to IDLE (load dropped).
- mem_rvalid in IDLE without a load transfer is ignored.
- in_valid during LOAD_WAIT is not accepted; the upstream stage must hold its inputs.
- ext(), applied to lane = mem_rdata shifted right by 8*addr_lo:
  - Byte: lane[7:0], sign- or zero-extended.
  - Half: lane[15:0]. Half uses addr_lo[1] only; addr_lo[0] is ignored.
  - Word/reserved: mem_rdata unchanged; addr_lo ignored.
- err clears only on rst.
- rst asserted mid-LOAD_WAIT: next cycle is IDLE with the reset values. A late mem_rvalid after that is ignored unless a new load transfer coincides with it.

Test Plan:
- ALU op: transfer wreg = 5, result = 0x12345678 in cycle N -> cycle N+1: wreg_b = 5, w_data_b = 0x12345678, we_b = 1; cycle N+2 idle: wreg_b = 0, we_b = 0.
- r0 write: transfer wreg = 0, result = 0xFFFFFFFF -> wreg_b = 0, we_b = 0; no forwarding match possible.
- Zero-wait signed byte load: wreg = 9, ldsize = 0, signed, addr_lo = 3, mem_rdata = 0x80AABBCC with rvalid in the same cycle -> next cycle w_data_b = 0xFFFFFF80, wreg_b = 9; stall never asserts.
- Three-wait unsigned half load: addr_lo = 2, rdata = 0xBEEF1234 arrives 3 cycles later -> stall = 1 and in_ready = 0 for 3 cycles; during them wreg_b = 0; then w_data_b = 0x0000BEEF, wreg_b = latched reg.
- Back-to-back: ALU then load issued the cycle after the ALU commit -> both commit in order; no bubble on the zero-wait path.
- Timeout with TIMEOUT = 4: load never answered -> err = 1 after 4 wait cycles, no commit, state IDLE. Then rst mid-LOAD_WAIT of a second load -> all outputs return to reset values, err = 0.
